chess_clock_ctrl: RTL



---
 rtl/chess_clock_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/chess_clock_ctrl.sv
// chess_clock_ctrl: two-player chess clock controller.
// Owns both players' BCD mm:ss times, the setup minutes, the turn state
// machine and the single 1 Hz prescaler shared by whichever side is running.
module chess_clock_ctrl #(
    parameter int          TICK_DIV    = 100_000_000,
    parameter logic [7:0]  DEFAULT_MIN = 8'h05
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_set,
    input  logic        btn_add,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        btn_pause,
    output logic [7:0]  set_min,
    output logic [15:0] time_a,
    output logic [15:0] time_b,
    output logic [1:0]  active,
    output logic        paused,
    output logic        flag_a,
    output logic        flag_b
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [15:0]    RESET_TIME = {DEFAULT_MIN, 8'h00};

    typedef enum logic [2:0] {
        ST_SET,
        ST_READY,
        ST_RUN_A,
        ST_RUN_B,
        ST_PAUSE,
        ST_FLAG
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     set_min_q, set_min_d;
    logic [15:0]    time_a_q, time_a_d;
    logic [15:0]    time_b_q, time_b_d;
    logic [1:0]     active_q, active_d;
    logic           paused_q, paused_d;
    logic           flag_a_q, flag_a_d;
    logic           flag_b_q, flag_b_d;
    logic           resume_b_q, resume_b_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [3:0]     btn_q, btn_d;
    logic [3:0]     btn_prev_q, btn_prev_d;

    logic           add_rise, a_rise, b_rise, pause_rise;
    logic           tick;
    logic [15:0]    dec_a, dec_b;

    // One-minute BCD increment of the setup value, wrapping 59 back to 00.
    function automatic logic [7:0] bcd_inc_min(input logic [7:0] m);
        logic [7:0] r;
        r = m;
        if (m[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (m[7:4] == 4'd5) ? 4'd0 : m[7:4] + 4'd1;
        end else begin
            r[3:0] = m[3:0] + 4'd1;
        end
        return r;
    endfunction

    // One-second BCD decrement of an mm:ss time; callers never pass 0000.
    function automatic logic [15:0] bcd_dec_sec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Button sampling pipeline: current sample plus previous sample for rise detection.
    always_comb begin
        btn_d      = {btn_pause, btn_b, btn_a, btn_add};
        btn_prev_d = btn_q;
        add_rise   = btn_q[0] & ~btn_prev_q[0];
        a_rise     = btn_q[1] & ~btn_prev_q[1];
        b_rise     = btn_q[2] & ~btn_prev_q[2];
        pause_rise = btn_q[3] & ~btn_prev_q[3];
    end

    // Next-state, time and prescaler logic; mode_set overrides every state.
    always_comb begin
        state_d    = state_q;
        set_min_d  = set_min_q;
        time_a_d   = time_a_q;
        time_b_d   = time_b_q;
        flag_a_d   = flag_a_q;
        flag_b_d   = flag_b_q;
        resume_b_d = resume_b_q;
        presc_d    = presc_q;
        tick       = 1'b0;
        dec_a      = bcd_dec_sec(time_a_q);
        dec_b      = bcd_dec_sec(time_b_q);

        if (mode_set) begin
            state_d  = ST_SET;
            flag_a_d = 1'b0;
            flag_b_d = 1'b0;
            presc_d  = '0;
            if (state_q == ST_SET && add_rise) begin
                set_min_d = bcd_inc_min(set_min_q);
            end
            time_a_d = {set_min_d, 8'h00};
            time_b_d = {set_min_d, 8'h00};
        end else begin
            case (state_q)
                ST_SET: begin
                    state_d = ST_READY;
                    presc_d = '0;
                end
                ST_READY: begin
                    presc_d = '0;
                    if (set_min_q != 8'h00) begin
                        if (a_rise) begin
                            state_d = ST_RUN_B;
                        end else if (b_rise) begin
                            state_d = ST_RUN_A;
                        end
                    end
                end
                ST_RUN_A: begin
                    tick    = (presc_q == PRESC_MAX);
                    presc_d = tick ? '0 : (pause_rise ? presc_q : presc_q + PW'(1));
                    if (tick) begin
                        time_a_d = dec_a;
                    end
                    if (tick && dec_a == 16'h0000) begin
                        state_d  = ST_FLAG;
                        flag_a_d = 1'b1;
                        presc_d  = '0;
                    end else if (pause_rise) begin
                        state_d    = ST_PAUSE;
                        resume_b_d = 1'b0;
                    end else if (a_rise) begin
                        state_d = ST_RUN_B;
                        presc_d = '0;
                    end
                end
                ST_RUN_B: begin
                    tick    = (presc_q == PRESC_MAX);
                    presc_d = tick ? '0 : (pause_rise ? presc_q : presc_q + PW'(1));
                    if (tick) begin
                        time_b_d = dec_b;
                    end
                    if (tick && dec_b == 16'h0000) begin
                        state_d  = ST_FLAG;
                        flag_b_d = 1'b1;
                        presc_d  = '0;
                    end else if (pause_rise) begin
                        state_d    = ST_PAUSE;
                        resume_b_d = 1'b1;
                    end else if (b_rise) begin
                        state_d = ST_RUN_A;
                        presc_d = '0;
                    end
                end
                ST_PAUSE: begin
                    if (pause_rise) begin
                        state_d = resume_b_q ? ST_RUN_B : ST_RUN_A;
                    end
                end
                ST_FLAG: begin
                    presc_d = '0;
                end
                default: begin
                    state_d = ST_SET;
                    presc_d = '0;
                end
            endcase
        end

        active_d = (state_d == ST_RUN_A) ? 2'b01 :
                   (state_d == ST_RUN_B) ? 2'b10 : 2'b00;
        paused_d = (state_d == ST_PAUSE);
    end

    // State, time and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SET;
            set_min_q  <= DEFAULT_MIN;
            time_a_q   <= RESET_TIME;
            time_b_q   <= RESET_TIME;
            active_q   <= 2'b00;
            paused_q   <= 1'b0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            resume_b_q <= 1'b0;
            presc_q    <= '0;
            btn_q      <= 4'b0000;
            btn_prev_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            set_min_q  <= set_min_d;
            time_a_q   <= time_a_d;
            time_b_q   <= time_b_d;
            active_q   <= active_d;
            paused_q   <= paused_d;
            flag_a_q   <= flag_a_d;
            flag_b_q   <= flag_b_d;
            resume_b_q <= resume_b_d;
            presc_q    <= presc_d;
            btn_q      <= btn_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign set_min = set_min_q;
    assign time_a  = time_a_q;
    assign time_b  = time_b_q;
    assign active  = active_q;
    assign paused  = paused_q;
    assign flag_a  = flag_a_q;
    assign flag_b  = flag_b_q;

endmodule
